// File: rtl/upower_mem_pkg.sv
// Shared definitions for the uPower load/store path: opcodes, access size,
// error codes, initiator FSM states and opcode decode helpers.
package upower_mem_pkg;

  localparam logic [5:0] OP_LWZ = 6'd32;
  localparam logic [5:0] OP_LBZ = 6'd34;
  localparam logic [5:0] OP_STW = 6'd36;
  localparam logic [5:0] OP_STB = 6'd38;
  localparam logic [5:0] OP_LHZ = 6'd40;
  localparam logic [5:0] OP_LHA = 6'd42;
  localparam logic [5:0] OP_STH = 6'd44;
  localparam logic [5:0] OP_LD  = 6'd58;
  localparam logic [5:0] OP_STD = 6'd62;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD} mem_size_e;
  typedef enum logic [1:0] {ERR_OK, ERR_MISALIGN, ERR_TIMEOUT, ERR_ILLEGAL} err_e;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP, ST_DONE} state_e;

  typedef struct packed {
    logic      legal;
    logic      is_load;
    mem_size_e size;
  } op_info_t;

  // Classify a primary opcode; anything outside the table is illegal.
  function automatic op_info_t decode_op(input logic [5:0] op);
    op_info_t i;
    i.legal   = 1'b1;
    i.is_load = 1'b0;
    i.size    = SZ_BYTE;
    case (op)
      OP_LBZ: begin i.is_load = 1'b1; i.size = SZ_BYTE;  end
      OP_LHZ: begin i.is_load = 1'b1; i.size = SZ_HALF;  end
      OP_LHA: begin i.is_load = 1'b1; i.size = SZ_HALF;  end
      OP_LWZ: begin i.is_load = 1'b1; i.size = SZ_WORD;  end
      OP_LD:  begin i.is_load = 1'b1; i.size = SZ_DWORD; end
      OP_STB: i.size = SZ_BYTE;
      OP_STH: i.size = SZ_HALF;
      OP_STW: i.size = SZ_WORD;
      OP_STD: i.size = SZ_DWORD;
      default: i.legal = 1'b0;
    endcase
    return i;
  endfunction

  // Natural alignment check on the low address bits.
  function automatic logic misaligned(input mem_size_e sz, input logic [2:0] ea_lo);
    case (sz)
      SZ_HALF:  return ea_lo[0];
      SZ_WORD:  return |ea_lo[1:0];
      SZ_DWORD: return |ea_lo;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Combinational load-data extension: picks the low byte/half/word of the
// raw memory data and zero- or sign-extends it according to the opcode.
module lsu_extend
  import upower_mem_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [5:0]        opcode,
  input  logic [DATA_W-1:0] raw,
  output logic [DATA_W-1:0] result
);

  // Select and extend; ld (and anything else) passes the full width.
  always_comb begin
    result = raw;
    case (opcode)
      OP_LBZ: result = {{(DATA_W-8){1'b0}},  raw[7:0]};
      OP_LHZ: result = {{(DATA_W-16){1'b0}}, raw[15:0]};
      OP_LHA: result = {{(DATA_W-16){raw[15]}}, raw[15:0]};
      OP_LWZ: result = {{(DATA_W-32){1'b0}}, raw[31:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: takes one decoded load/store from execute, runs a
// req/ack access to data memory, extends load data into a one-cycle
// writeback and reports completion with an error code.
module lsu_mem_initiator
  import upower_mem_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [5:0]        cmd_opcode,
  input  logic [ADDR_W-1:0] cmd_ea,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [4:0]        cmd_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_size,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_en,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              done,
  output logic [1:0]        err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  err_e              err_q, err_d;
  op_info_t          cmd_info;
  logic              accept;
  logic [5:0]        op_q;
  logic [ADDR_W-1:0] ea_q;
  logic [DATA_W-1:0] wdata_q, wdata_mask;
  logic [DATA_W-1:0] rdata_q, ext_data;
  logic [4:0]        rd_q;
  logic              is_load_q;
  mem_size_e         size_q;
  logic [CNT_W-1:0]  cnt_q;

  assign cmd_info = decode_op(cmd_opcode);
  assign accept   = (state_q == ST_IDLE) && cmd_valid;

  // Size-mask store data at accept so the memory side only sees clean bits.
  always_comb begin
    wdata_mask = '0;
    case (cmd_info.size)
      SZ_BYTE:  wdata_mask[7:0]  = cmd_wdata[7:0];
      SZ_HALF:  wdata_mask[15:0] = cmd_wdata[15:0];
      SZ_WORD:  wdata_mask[31:0] = cmd_wdata[31:0];
      default:  wdata_mask       = cmd_wdata;
    endcase
  end

  // State and error-code register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Next-state: decode/alignment errors skip memory entirely; ack beats timeout.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (!cmd_info.legal) begin
            state_d = ST_DONE;
            err_d   = ERR_ILLEGAL;
          end else if (misaligned(cmd_info.size, cmd_ea[2:0])) begin
            state_d = ST_DONE;
            err_d   = ERR_MISALIGN;
          end else begin
            state_d = ST_REQ;
            err_d   = ERR_OK;
          end
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          state_d = ST_RESP;
        end else if (cnt_q == CNT_W'(1)) begin
          // Counter reaches 0 at the end of this cycle: TIMEOUT REQ cycles seen.
          state_d = ST_DONE;
          err_d   = ERR_TIMEOUT;
        end
      end
      ST_RESP: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Command latch, timeout down-counter and read-data capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q      <= '0;
      ea_q      <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      is_load_q <= 1'b0;
      size_q    <= SZ_BYTE;
      cnt_q     <= '0;
      rdata_q   <= '0;
    end else begin
      if (accept) begin
        op_q      <= cmd_opcode;
        ea_q      <= cmd_ea;
        wdata_q   <= cmd_info.is_load ? '0 : wdata_mask;
        rd_q      <= cmd_rd;
        is_load_q <= cmd_info.is_load;
        size_q    <= cmd_info.size;
        cnt_q     <= CNT_W'(TIMEOUT);
      end
      if (state_q == ST_REQ) begin
        cnt_q <= cnt_q - CNT_W'(1);
        if (mem_ack) rdata_q <= mem_rdata;
      end
    end
  end

  lsu_extend #(.DATA_W(DATA_W)) u_extend (
    .opcode (op_q),
    .raw    (rdata_q),
    .result (ext_data)
  );

  // Outputs decoded from state; everything is zero outside its own state.
  always_comb begin
    cmd_ready = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_size  = '0;
    wb_en     = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
    done      = 1'b0;
    err       = '0;
    case (state_q)
      ST_IDLE: cmd_ready = 1'b1;
      ST_REQ: begin
        mem_req   = 1'b1;
        mem_we    = !is_load_q;
        mem_addr  = ea_q;
        mem_wdata = wdata_q;
        mem_size  = size_q;
      end
      ST_RESP: begin
        if (is_load_q) begin
          wb_en   = 1'b1;
          wb_rd   = rd_q;
          wb_data = ext_data;
        end
      end
      default: begin
        done = 1'b1;
        err  = err_q;
      end
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator: each task runs one scenario and
// compares observed handshake/writeback behaviour against hand-worked values.
module tb_lsu_mem_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_opcode;
  logic [63:0] cmd_ea;
  logic [63:0] cmd_wdata;
  logic [4:0]  cmd_rd;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        done;
  logic [1:0]  err;

  int checks = 0;
  int failures = 0;

  // Observations recorded by run_cmd
  int          req_cycles, last_req_cyc, wb_cnt, wb_cyc, done_cyc, done_cnt;
  logic        req_stable;
  logic        o_we;
  logic [63:0] o_addr, o_wdata, o_wb_data;
  logic [1:0]  o_size, o_err;
  logic [4:0]  o_wb_rd;
  logic        o_ready_busy, o_ready_after;

  always #5 clk = ~clk;

  lsu_mem_initiator #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_ea(cmd_ea), .cmd_wdata(cmd_wdata), .cmd_rd(cmd_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .done(done), .err(err)
  );

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Issue one command and observe cycles 1..40 after accept (cycle 0).
  // ack_cyc = 0 means the responder never acks.
  task automatic run_cmd(input logic [5:0] op, input logic [63:0] ea, input logic [63:0] wd,
                         input logic [4:0] rd, input int ack_cyc, input logic [63:0] rdata);
    req_cycles = 0; last_req_cyc = 0; wb_cnt = 0; wb_cyc = 0; done_cyc = 0; done_cnt = 0;
    req_stable = 1'b1; o_we = 1'b0; o_addr = '0; o_wdata = '0; o_size = '0; o_err = '0;
    o_wb_rd = '0; o_wb_data = '0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_ea = ea; cmd_wdata = wd; cmd_rd = rd;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_opcode = 6'd0; cmd_ea = '0; cmd_wdata = '0; cmd_rd = '0;
    o_ready_busy = cmd_ready;
    for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
      if (c > 1) @(negedge clk);
      if (mem_req) begin
        req_cycles++;
        last_req_cyc = c;
        if (req_cycles == 1) begin
          o_we = mem_we; o_addr = mem_addr; o_wdata = mem_wdata; o_size = mem_size;
        end else if (mem_we !== o_we || mem_addr !== o_addr || mem_wdata !== o_wdata ||
                     mem_size !== o_size) begin
          req_stable = 1'b0;
        end
      end
      if (wb_en) begin wb_cnt++; wb_cyc = c; o_wb_rd = wb_rd; o_wb_data = wb_data; end
      if (done) begin done_cyc = c; done_cnt++; o_err = err; end
      mem_ack   = (c == ack_cyc);
      mem_rdata = rdata;
    end
    @(negedge clk);
    mem_ack = 1'b0;
    o_ready_after = cmd_ready;
    if (done) done_cnt++;
    if (wb_en) wb_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    checks++; if ({mem_req, mem_we, wb_en, done, err} !== 6'b0) begin failures++;
      $display("FAIL reset_ctrl got=%b exp=0", {mem_req, mem_we, wb_en, done, err}); end
    checks++; if ({mem_addr, mem_wdata, mem_size, wb_rd, wb_data} !== '0) begin failures++;
      $display("FAIL reset_data got=%h exp=0", {mem_addr, mem_wdata, wb_data}); end
    rst_n = 1'b1;
  endtask

  task automatic test_store_byte();
    run_cmd(6'd38, 64'h10, 64'h1122334455667788, 5'd0, 2, 64'hFFFF_FFFF_FFFF_FFFF);
    checks++; if (o_ready_busy !== 1'b0) begin failures++; $display("FAIL stb_busy_ready got=%b exp=0", o_ready_busy); end
    checks++; if (req_cycles !== 2) begin failures++; $display("FAIL stb_req_cycles got=%0d exp=2", req_cycles); end
    checks++; if ({o_we, o_size} !== 3'b100) begin failures++; $display("FAIL stb_we_size got=%b exp=100", {o_we, o_size}); end
    checks++; if (o_wdata !== 64'h88) begin failures++; $display("FAIL stb_wdata got=%h exp=88", o_wdata); end
    checks++; if (o_addr !== 64'h10) begin failures++; $display("FAIL stb_addr got=%h exp=10", o_addr); end
    checks++; if (!req_stable) begin failures++; $display("FAIL stb_req_stable got=0 exp=1"); end
    checks++; if (wb_cnt !== 0) begin failures++; $display("FAIL stb_wb got=%0d exp=0", wb_cnt); end
    checks++; if (done_cyc !== 4 || o_err !== 2'd0) begin failures++;
      $display("FAIL stb_done got=cyc%0d err%0d exp=cyc4 err0", done_cyc, o_err); end
    checks++; if (o_ready_after !== 1'b1 || done_cnt !== 1) begin failures++;
      $display("FAIL stb_after got=ready%b dones%0d exp=ready1 dones1", o_ready_after, done_cnt); end
  endtask

  task automatic test_store_sizes();
    run_cmd(6'd44, 64'h2, 64'h1122334455667788, 5'd0, 1, 64'h0);
    checks++; if ({o_we, o_size, o_wdata} !== {1'b1, 2'd1, 64'h7788}) begin failures++;
      $display("FAIL sth got=we%b sz%0d %h exp=we1 sz1 7788", o_we, o_size, o_wdata); end
    run_cmd(6'd36, 64'h4, 64'h1122334455667788, 5'd0, 1, 64'h0);
    checks++; if ({o_we, o_size, o_wdata} !== {1'b1, 2'd2, 64'h55667788}) begin failures++;
      $display("FAIL stw got=we%b sz%0d %h exp=we1 sz2 55667788", o_we, o_size, o_wdata); end
    run_cmd(6'd62, 64'h8, 64'h1122334455667788, 5'd0, 3, 64'h0);
    checks++; if ({o_we, o_size, o_wdata} !== {1'b1, 2'd3, 64'h1122334455667788}) begin failures++;
      $display("FAIL std got=we%b sz%0d %h exp=we1 sz3 1122334455667788", o_we, o_size, o_wdata); end
    checks++; if (done_cyc !== 5 || o_err !== 2'd0 || wb_cnt !== 0) begin failures++;
      $display("FAIL std_done got=cyc%0d err%0d wb%0d exp=cyc5 err0 wb0", done_cyc, o_err, wb_cnt); end
  endtask

  task automatic test_loads();
    run_cmd(6'd42, 64'h4, 64'h0, 5'd3, 1, 64'h000000000000F00D);
    checks++; if ({o_we, o_size, o_addr} !== {1'b0, 2'd1, 64'h4}) begin failures++;
      $display("FAIL lha_req got=we%b sz%0d %h exp=we0 sz1 4", o_we, o_size, o_addr); end
    checks++; if (wb_cnt !== 1 || wb_cyc !== 2 || o_wb_rd !== 5'd3) begin failures++;
      $display("FAIL lha_wb got=n%0d cyc%0d rd%0d exp=n1 cyc2 rd3", wb_cnt, wb_cyc, o_wb_rd); end
    checks++; if (o_wb_data !== 64'hFFFFFFFFFFFFF00D) begin failures++;
      $display("FAIL lha_data got=%h exp=FFFFFFFFFFFFF00D", o_wb_data); end
    checks++; if (done_cyc !== 3 || o_err !== 2'd0) begin failures++;
      $display("FAIL lha_done got=cyc%0d err%0d exp=cyc3 err0", done_cyc, o_err); end
    run_cmd(6'd40, 64'h4, 64'h0, 5'd3, 1, 64'h000000000000F00D);
    checks++; if (o_wb_data !== 64'h000000000000F00D || wb_cnt !== 1) begin failures++;
      $display("FAIL lhz_data got=%h n%0d exp=000000000000F00D n1", o_wb_data, wb_cnt); end
    run_cmd(6'd34, 64'h7, 64'h0, 5'd17, 2, 64'hAAAABBBBCCCC8899);
    checks++; if (o_wb_data !== 64'h99 || o_wb_rd !== 5'd17 || o_size !== 2'd0) begin failures++;
      $display("FAIL lbz got=%h rd%0d sz%0d exp=99 rd17 sz0", o_wb_data, o_wb_rd, o_size); end
    run_cmd(6'd32, 64'h8, 64'h0, 5'd31, 1, 64'hDEADBEEF80000001);
    checks++; if (o_wb_data !== 64'h80000001 || o_wb_rd !== 5'd31) begin failures++;
      $display("FAIL lwz got=%h rd%0d exp=80000001 rd31", o_wb_data, o_wb_rd); end
  endtask

  task automatic test_errors();
    // Ack offered during DONE must be ignored.
    run_cmd(6'd32, 64'h6, 64'h0, 5'd4, 1, 64'h1234);
    checks++; if (req_cycles !== 0 || wb_cnt !== 0) begin failures++;
      $display("FAIL lwz_mis got=req%0d wb%0d exp=req0 wb0", req_cycles, wb_cnt); end
    checks++; if (done_cyc !== 1 || o_err !== 2'd1 || o_ready_after !== 1'b1) begin failures++;
      $display("FAIL lwz_mis_done got=cyc%0d err%0d rdy%b exp=cyc1 err1 rdy1", done_cyc, o_err, o_ready_after); end
    run_cmd(6'd42, 64'h5, 64'h0, 5'd4, 0, 64'h0);
    checks++; if (req_cycles !== 0 || done_cyc !== 1 || o_err !== 2'd1) begin failures++;
      $display("FAIL lha_mis got=req%0d cyc%0d err%0d exp=req0 cyc1 err1", req_cycles, done_cyc, o_err); end
    run_cmd(6'd62, 64'h4, 64'h0, 5'd0, 0, 64'h0);
    checks++; if (req_cycles !== 0 || o_err !== 2'd1) begin failures++;
      $display("FAIL std_mis got=req%0d err%0d exp=req0 err1", req_cycles, o_err); end
    run_cmd(6'd31, 64'h0, 64'h0, 5'd5, 0, 64'h0);
    checks++; if (req_cycles !== 0 || wb_cnt !== 0 || done_cyc !== 1 || o_err !== 2'd3) begin failures++;
      $display("FAIL illegal got=req%0d wb%0d cyc%0d err%0d exp=req0 wb0 cyc1 err3", req_cycles, wb_cnt, done_cyc, o_err); end
  endtask

  task automatic test_timeout();
    run_cmd(6'd58, 64'h8, 64'h0, 5'd9, 0, 64'h0);
    checks++; if (req_cycles !== 16 || last_req_cyc !== 16) begin failures++;
      $display("FAIL to_req got=n%0d last%0d exp=n16 last16", req_cycles, last_req_cyc); end
    checks++; if (done_cyc !== 17 || o_err !== 2'd2 || wb_cnt !== 0) begin failures++;
      $display("FAIL to_done got=cyc%0d err%0d wb%0d exp=cyc17 err2 wb0", done_cyc, o_err, wb_cnt); end
    checks++; if (o_ready_after !== 1'b1) begin failures++; $display("FAIL to_ready got=%b exp=1", o_ready_after); end
    run_cmd(6'd58, 64'h8, 64'h0, 5'd9, 16, 64'h0123456789ABCDEF);
    checks++; if (req_cycles !== 16 || wb_cnt !== 1 || wb_cyc !== 17) begin failures++;
      $display("FAIL edge_ack got=req%0d wb%0d cyc%0d exp=req16 wb1 cyc17", req_cycles, wb_cnt, wb_cyc); end
    checks++; if (o_wb_data !== 64'h0123456789ABCDEF || done_cyc !== 18 || o_err !== 2'd0) begin failures++;
      $display("FAIL edge_done got=%h cyc%0d err%0d exp=0123456789ABCDEF cyc18 err0", o_wb_data, done_cyc, o_err); end
  endtask

  task automatic test_reset_mid();
    int extra;
    extra = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = 6'd62; cmd_ea = 64'h18; cmd_wdata = 64'hCAFE; cmd_rd = 5'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL mid_req_before got=%b exp=1", mem_req); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (cmd_ready !== 1'b1 || {mem_req, mem_we, wb_en, done, err} !== 6'b0 ||
                  mem_addr !== '0 || mem_wdata !== '0) begin failures++;
      $display("FAIL mid_reset got=rdy%b req%b we%b addr%h exp=rdy1 zeros", cmd_ready, mem_req, mem_we, mem_addr); end
    mem_ack = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (wb_en || done || mem_req || !cmd_ready) extra++;
    end
    mem_ack = 1'b0;
    checks++; if (extra !== 0) begin failures++; $display("FAIL mid_after got=%0d stray cycles exp=0", extra); end
  endtask

  task automatic test_back_to_back();
    run_cmd(6'd38, 64'h21, 64'hAB, 5'd0, 1, 64'h0);
    run_cmd(6'd58, 64'h20, 64'h0, 5'd12, 1, 64'hFEDCBA9876543210);
    checks++; if (o_wb_data !== 64'hFEDCBA9876543210 || o_wb_rd !== 5'd12 || done_cyc !== 3) begin failures++;
      $display("FAIL b2b got=%h rd%0d cyc%0d exp=FEDCBA9876543210 rd12 cyc3", o_wb_data, o_wb_rd, done_cyc); end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0; cmd_ea = '0; cmd_wdata = '0;
    cmd_rd = '0; mem_ack = 1'b0; mem_rdata = '0;
    test_reset();
    test_store_byte();
    test_store_sizes();
    test_loads();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator between the uPower execute stage and the data-memory responder.
- Accepts one decoded load/store per command and drives a req/ack handshake to data memory, sizing store data by opcode.
- Size- and sign-extends load data and emits a single-cycle register-file writeback.
- Flags misaligned or timed-out accesses to the control unit.

Parameters:
- ADDR_W, 64, effective-address width
- DATA_W, 64, data width
- TIMEOUT, 16, cycles to wait for mem_ack before aborting

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  execute stage presents a command
- cmd_ready  out  1  initiator idle and can accept a command
- cmd_opcode  in  6  uPower primary opcode
- cmd_ea  in  ADDR_W  effective address
- cmd_wdata  in  DATA_W  store source register value
- cmd_rd  in  5  load destination register
- mem_req  out  1  request to data memory
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  size-masked store data
- mem_size  out  2  0 = byte, 1 = half, 2 = word, 3 = dword
- mem_ack  in  1  responder completion
- mem_rdata  in  DATA_W  read data, valid with mem_ack on reads
- wb_en  out  1  register writeback strobe, one cycle
- wb_rd  out  5  writeback register
- wb_data  out  DATA_W  extended load result
- done  out  1  one-cycle completion pulse
- err  out  2  0 = ok, 1 = misaligned, 2 = timeout, 3 = illegal opcode; valid with done

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, cmd_ready=1; all other outputs 0, including mem_req, wb_en, done and err. Reset mid-transaction drops mem_req on the next edge with no writeback.
- Opcode table:
  - Loads: lbz 34 byte zero-extend; lhz 40 half zero-extend; lha 42 half sign-extend; lwz 32 word zero-extend; ld 58 dword.
  - Stores: stb 38 byte; sth 44 half; stw 36 word; std 62 dword.
  - Any other opcode is illegal.
- Store data: mem_wdata = cmd_wdata masked to size, upper bits zero.
- IDLE:
  - A command is accepted when cmd_valid and cmd_ready are both 1. The initiator latches opcode, ea, wdata and rd, and cmd_ready drops on the next cycle.
  - Illegal opcode: go to DONE with err=3.
  - Misaligned address: go to DONE with err=1. Misaligned means ea[0]≠0 for half, ea[1:0]≠0 for word, ea[2:0]≠0 for dword.
  - Otherwise: go to REQ.
- REQ:
  - mem_req=1 and mem_addr, mem_we, mem_wdata, mem_size all stable until ack. A down-counter is loaded with TIMEOUT on entry.
  - mem_ack=1 captures mem_rdata and goes to RESP.
  - Counter reaching 0 without ack: drop mem_req and go to DONE with err=2.
  - An ack arriving in the same cycle the counter hits 0 takes priority; the access is not timed out.
- RESP: mem_req=0. For a load, drive wb_en=1, wb_rd and the extended wb_data for exactly one cycle. Stores produce no writeback. Go to DONE.
- DONE: done=1 and err valid for one cycle, then return to IDLE with cmd_ready=1.
- No writeback ever occurs on err≠0.
- mem_ack seen while not in REQ is ignored.
- Latency: accept at cycle 0, mem_req in cycles 1..k where k is the ack cycle, wb_en at k+1, done at k+2. Minimum 4 cycles per command.
- One outstanding transaction; no pipelining.

Decomposition:
- Shared package upower_mem_pkg:
  - opcode constants (OP_LBZ=34 … OP_STD=62)
  - mem_size encoding
  - err encoding
  - FSM state enum (IDLE, REQ, RESP, DONE)
- Sub-module lsu_extend: combinational size/sign extension (opcode + raw data → 64-bit result). Reused later by the load-update variants.

Test Plan:
- stb, ea=0x10, wdata=0x1122334455667788, ack after 2 cycles → mem_we=1, mem_size=0, mem_wdata=0x88, mem_addr=0x10, no wb_en, done with err=0.
- lha, ea=0x4, rd=3, mem_rdata=0x000000000000F00D → wb_en one cycle, wb_rd=3, wb_data=0xFFFFFFFFFFFFF00D; lhz with the same data → 0x000000000000F00D.
- lwz, ea=0x6 → no mem_req ever asserted, done with err=1 one cycle after accept, no writeback.
- ld, ea=0x8, mem_ack never asserted, TIMEOUT=16 → mem_req high 16 cycles then low, done with err=2, cmd_ready returns to 1.
- ld with ack on exactly the 16th REQ cycle → normal completion, err=0, writeback occurs.
- std in progress with mem_req high, rst_n=0 for one edge → all outputs 0 and cmd_ready=1 next cycle; no wb_en or done. Opcode 31 → err=3.
